reg_wr_arbiter: RTL

- Shares the single write port of the 8 x 16-bit `reg_file` between two independent write requesters, e.g. ALU writeback and load return.
- Each requester gets a small request FIFO with a valid/ready handshake.
- A round-robin arbiter drains one FIFO entry per cycle into registered `wr`/`wr_addr`/`d_in` outputs, which connect directly to `reg_file`.
- A hold input freezes draining, for example while a debug read sequence owns the file.

---
 rtl/reg_wr_arbiter.sv | 133 +++++++++++++
 1 files changed

// File: rtl/reg_wr_arbiter.sv
// Two-requester write arbiter for reg_file: per-requester request FIFOs drained
// round-robin, one entry per cycle, into registered write-port outputs.

module reg_wr_fifo #(
  parameter int DW    = 16,
  parameter int AW    = 3,
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push_valid,
  input  logic [AW-1:0] push_addr,
  input  logic [DW-1:0] push_data,
  output logic          ready,
  input  logic          pop,
  output logic          empty,
  output logic [AW-1:0] head_addr,
  output logic [DW-1:0] head_data
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0][AW+DW-1:0] mem;
  logic [PW-1:0]               wp, rp;
  logic [CW-1:0]               count;
  logic                        push, pop_ok;

  // ready is a pure function of occupancy, so a full FIFO stays not-ready
  // even in a cycle where it is being popped.
  assign ready  = (count < CW'(DEPTH));
  assign empty  = (count == '0);
  assign push   = push_valid & ready;
  assign pop_ok = pop & ~empty;
  assign {head_addr, head_data} = mem[rp];

  always_ff @(posedge clk) begin
    if (reset) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wp] <= {push_addr, push_data};
        wp      <= wp + 1'b1;
      end
      if (pop_ok) rp <= rp + 1'b1;
      case ({push, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

module reg_wr_arbiter #(
  parameter int DW    = 16,
  parameter int AW    = 3,
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0_valid,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_data,
  output logic          req0_ready,
  input  logic          req1_valid,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_data,
  output logic          req1_ready,
  input  logic          hold,
  output logic          wr,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] d_in,
  output logic          wr_src,
  output logic          idle
);
  localparam int NREQ = 2;

  logic [NREQ-1:0]         valid, ready, pop, empty;
  logic [NREQ-1:0][AW-1:0] addr, head_addr;
  logic [NREQ-1:0][DW-1:0] data, head_data;
  logic                    prio, any_gnt, gnt;

  assign valid = {req1_valid, req0_valid};
  assign addr  = {req1_addr, req0_addr};
  assign data  = {req1_data, req0_data};
  assign req0_ready = ready[0];
  assign req1_ready = ready[1];

  for (genvar g = 0; g < NREQ; g++) begin : g_fifo
    reg_wr_fifo #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .push_valid (valid[g]),
      .push_addr  (addr[g]),
      .push_data  (data[g]),
      .ready      (ready[g]),
      .pop        (pop[g]),
      .empty      (empty[g]),
      .head_addr  (head_addr[g]),
      .head_data  (head_data[g])
    );
  end

  // With both heads present prio decides; otherwise the lone non-empty FIFO wins.
  always_comb begin
    any_gnt = ~hold & ~(empty[0] & empty[1]);
    gnt     = (~empty[0] & ~empty[1]) ? prio : empty[0];
    pop     = '0;
    pop[gnt] = any_gnt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr      <= 1'b0;
      wr_addr <= '0;
      d_in    <= '0;
      wr_src  <= 1'b0;
      prio    <= 1'b0;
    end else begin
      wr <= any_gnt;
      if (any_gnt) begin
        wr_addr <= head_addr[gnt];
        d_in    <= head_data[gnt];
        wr_src  <= gnt;
        prio    <= ~gnt;
      end
    end
  end

  assign idle = empty[0] & empty[1] & ~wr;
endmodule
